hilo_div_ctrl: RTL and testbench
================================

Name: hilo_div_ctrl

Overview:
- Multi-cycle iterative divider controller that owns all DIV/DIVU writes into the HI/LO pair of the register file.
- Sits beside the EX stage. It accepts a divide request, stalls the pipeline while it iterates, then issues one 64-bit {HI,LO} write using the register file's full-HILO flag encoding (3'b111).
- Also handles flush/cancel and divide-by-zero.

Parameters:
- WIDTH, 32, operand width; HI/LO results are each WIDTH bits, write data is 2*WIDTH.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > WIDTH.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- rst  in  1  synchronous active-low reset, sampled on the clk rising edge.
- start  in  1  divide request from EX; sampled only in IDLE.
- signed_op  in  1  1 = DIV (two's complement), 0 = DIVU; sampled with start.
- a  in  WIDTH  dividend; sampled with start.
- b  in  WIDTH  divisor; sampled with start.
- cancel  in  1  pipeline flush (exception/eret); aborts the operation in flight.
- stall  out  1  pipeline hold request.
- busy  out  1  1 in BUSY or DONE.
- hilo_we  out  1  register file write enable, one-cycle pulse.
- hilo_flag  out  3  register file write flag; 3'b111 while hilo_we=1, else 3'b000.
- hilo_wd  out  2*WIDTH  write data, {remainder, quotient} = {HI, LO}.

Behaviour:
- Reset (rst=0 at posedge): state=IDLE, counter=0; stall=0, busy=0, hilo_we=0, hilo_flag=0, hilo_wd=0. Reset overrides everything, including an operation in flight; no write is issued.
- States and transitions:
  - IDLE -> BUSY when start=1 and cancel=0.
  - BUSY -> DONE after WIDTH iterations.
  - DONE -> IDLE unconditionally.
  - BUSY or DONE -> IDLE when cancel=1.
- On accept (IDLE edge):
  - Latch magnitudes |a| and |b| (raw values when signed_op=0).
  - Latch quot_neg = signed_op & (a[MSB]^b[MSB]) and rem_neg = signed_op & a[MSB].
  - Clear the partial remainder; counter=0.
- BUSY: one restoring-division step per cycle.
  - Shift {rem, quot} left by 1 and trial-subtract |b| from the upper part.
  - If the trial is non-negative, commit it and set the quotient LSB.
  - counter increments each step; after the step with counter=WIDTH-1, go to DONE.
- Latency: start high in cycle 0 -> BUSY in cycles 1..WIDTH -> DONE in cycle WIDTH+1 (33 by default).
- DONE:
  - hilo_we=1 and hilo_flag=3'b111 for exactly one cycle.
  - hilo_wd = {rem_neg ? -rem : rem, quot_neg ? -quot : quot}, registered and stable for that cycle.
  - hilo_wd holds its last value afterwards.
- stall = (state==IDLE & start & ~cancel) | (state==BUSY). stall is 0 in DONE so the pipeline advances in the same cycle as the write.
- start is ignored in BUSY and DONE. A divide presented in the cycle after DONE (state IDLE) is accepted normally, so back-to-back divides have zero bubble.
- Divide by zero (b==0): no special path. The algorithm naturally yields quot = all ones and rem = |a|, then sign correction is applied. Same 33-cycle latency.
- cancel:
  - IDLE with start=1: request dropped, stall=0.
  - BUSY: abort, no write.
  - DONE: hilo_we forced to 0 that cycle.
- Signed corner case: a=0x80000000, b=0xFFFFFFFF, signed: quot=0x80000000, rem=0 (wraparound, no trap).

Optional Feature:
- Macro: HILO_DIV_DZ_TRAP_EN.
- Defined:
  - Adds output dz_err (1 bit, reset 0).
  - When b==0 on accept, the FSM goes IDLE->DONE directly, bypassing BUSY. stall is high only in the accept cycle.
  - In DONE: dz_err=1 for one cycle, hilo_we=0, hilo_flag=0, HI/LO untouched.
  - cancel in DONE also suppresses dz_err.
- Undefined: no dz_err port; divide by zero behaves as in Behaviour.

Test Plan:
- DIVU a=100, b=7 -> stall high cycles 0..32; cycle 33: hilo_we=1, hilo_flag=3'b111, hilo_wd=64'h00000002_0000000E.
- DIV a=-7 (0xFFFFFFF9), b=2 -> cycle 33: hilo_wd=64'hFFFFFFFF_FFFFFFFD (rem -1, quot -3).
- DIVU a=5, b=0, macro off -> hilo_wd=64'h00000005_FFFFFFFF at cycle 33. Macro on -> dz_err=1 at cycle 1, hilo_we=0, stall low from cycle 1.
- Start DIVU 9/3, assert cancel at cycle 10 -> state IDLE at cycle 11, stall=0, no hilo_we pulse at any later cycle.
- Start, drive rst=0 at cycle 20 -> all outputs 0 from cycle 21. With rst=1 and start reissued (a=9, b=3): hilo_wd=64'h00000000_00000003 33 cycles later.
- Back-to-back: DIVU 100/7, then start DIV a=0x80000000, b=0xFFFFFFFF in cycle 34 -> first write at 33, second at 67 with hilo_wd=64'h00000000_80000000.

Source files
------------

// File: rtl/hilo_div_ctrl.sv
// Iterative restoring divider that owns DIV/DIVU writes into the HI/LO register pair.
// Optional divide-by-zero trap: define HILO_DIV_DZ_TRAP_EN to add the dz_err output.
//
// state | meaning
// IDLE  | waiting for start; accept latches operand magnitudes and sign flags
// BUSY  | one restoring-division step per cycle, WIDTH steps in total
// DONE  | one-cycle {HI,LO} write (or dz_err pulse when the trap is enabled)
module hilo_div_ctrl #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_op,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 cancel,
    output logic                 stall,
    output logic                 busy,
    output logic                 hilo_we,
    output logic [2:0]           hilo_flag,
    output logic [2*WIDTH-1:0]   hilo_wd
`ifdef HILO_DIV_DZ_TRAP_EN
    ,
    output logic                 dz_err
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic [WIDTH-1:0]   rem;
    logic [WIDTH-1:0]   quot;
    logic [WIDTH-1:0]   dvs;
    logic               quot_neg;
    logic               rem_neg;

    logic [WIDTH-1:0]   a_mag;
    logic [WIDTH-1:0]   b_mag;
    logic [WIDTH:0]     shifted;
    logic [WIDTH:0]     diff;
    logic               fits;
    logic [WIDTH-1:0]   rem_nx;
    logic [WIDTH-1:0]   quot_nx;
    logic [WIDTH-1:0]   rem_fix;
    logic [WIDTH-1:0]   quot_fix;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    always_comb begin
        a_mag    = (signed_op && a[WIDTH-1]) ? -a : a;
        b_mag    = (signed_op && b[WIDTH-1]) ? -b : b;
        shifted  = {rem, quot[WIDTH-1]};
        diff     = shifted - {1'b0, dvs};
        // Unsigned compare keeps b==0 well defined: every trial commits, quot goes all ones.
        fits     = (shifted >= {1'b0, dvs});
        rem_nx   = fits ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
        quot_nx  = {quot[WIDTH-2:0], fits};
        rem_fix  = rem_neg  ? -rem_nx  : rem_nx;
        quot_fix = quot_neg ? -quot_nx : quot_nx;
    end

`ifdef HILO_DIV_DZ_TRAP_EN
    logic dz_q;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            cnt      <= '0;
            rem      <= '0;
            quot     <= '0;
            dvs      <= '0;
            quot_neg <= 1'b0;
            rem_neg  <= 1'b0;
            hilo_wd  <= '0;
`ifdef HILO_DIV_DZ_TRAP_EN
            dz_q     <= 1'b0;
`endif
        end else begin
            case (state)
                S_IDLE: begin
                    if (start && !cancel) begin
                        quot     <= a_mag;
                        dvs      <= b_mag;
                        rem      <= '0;
                        cnt      <= '0;
                        quot_neg <= signed_op & (a[WIDTH-1] ^ b[WIDTH-1]);
                        rem_neg  <= signed_op & a[WIDTH-1];
                        state    <= S_BUSY;
`ifdef HILO_DIV_DZ_TRAP_EN
                        dz_q     <= (b == '0);
                        if (b == '0)
                            state <= S_DONE;
`endif
                    end
                end
                S_BUSY: begin
                    if (cancel) begin
                        state <= S_IDLE;
                    end else begin
                        rem  <= rem_nx;
                        quot <= quot_nx;
                        cnt  <= cnt + 1'b1;
                        if (cnt == LAST) begin
                            state   <= S_DONE;
                            hilo_wd <= {rem_fix, quot_fix};
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // stall drops in DONE so the pipeline advances alongside the write.
    assign stall = ((state == S_IDLE) && start && !cancel) || (state == S_BUSY);
    assign busy  = (state == S_BUSY) || (state == S_DONE);

`ifdef HILO_DIV_DZ_TRAP_EN
    assign hilo_we = (state == S_DONE) && !cancel && !dz_q;
    assign dz_err  = (state == S_DONE) && !cancel && dz_q;
`else
    assign hilo_we = (state == S_DONE) && !cancel;
`endif
    assign hilo_flag = hilo_we ? 3'b111 : 3'b000;

endmodule

// File: tb/tb_hilo_div_ctrl.sv
// Directed bench for hilo_div_ctrl: latency, results, cancel, reset and back-to-back divides.
module tb_hilo_div_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        signed_op = 1'b0;
    logic        cancel = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        stall;
    logic        busy;
    logic        hilo_we;
    logic [2:0]  hilo_flag;
    logic [63:0] hilo_wd;
`ifdef HILO_DIV_DZ_TRAP_EN
    logic        dz_err;
`endif

    int total = 0;
    int bad   = 0;
    int we_cnt;

    always #5 clk = ~clk;

    hilo_div_ctrl #(.WIDTH(32), .CNT_W(6)) dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op),
        .a(a), .b(b), .cancel(cancel),
        .stall(stall), .busy(busy), .hilo_we(hilo_we),
        .hilo_flag(hilo_flag), .hilo_wd(hilo_wd)
`ifdef HILO_DIV_DZ_TRAP_EN
        , .dz_err(dz_err)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    // Issues a divide in the current cycle (cycle 0), checks cycles 1..33 and the idle cycle 34.
    // Returns positioned inside cycle 34 so a following divide starts there with no bubble.
    task automatic run_div(input logic sgn, input logic [31:0] va, input logic [31:0] vb,
                           input logic [63:0] exp_wd, input logic cdone);
        signed_op = sgn; a = va; b = vb; start = 1'b1;
        #1;
        chk("accept_stall", 64'(stall), 64'd1);
        next();
        start = 1'b0; a = '0; b = '0;
        for (int c = 1; c <= 32; c++) begin
            #1;
            chk($sformatf("busy_c%0d", c), 64'({stall, busy, hilo_we}), 64'd6);
            next();
        end
        if (cdone) cancel = 1'b1;
        #1;
        if (cdone) begin
            chk("done_cancel_we", 64'({hilo_we, hilo_flag, stall}), 64'd0);
        end else begin
            chk("done_ctl", 64'({hilo_we, hilo_flag, stall, busy}), 64'b111101);
            chk("done_wd", hilo_wd, exp_wd);
        end
        next();
        cancel = 1'b0;
        #1;
        chk("idle_after_done", 64'({busy, hilo_we, stall, hilo_flag}), 64'd0);
        if (!cdone) chk("wd_hold", hilo_wd, exp_wd);
    endtask

    initial begin
        next();
        next();
        #1;
        chk("reset_ctl", 64'({stall, busy, hilo_we, hilo_flag}), 64'd0);
        chk("reset_wd", hilo_wd, 64'd0);
        rst = 1'b1;
        next();

        // DIVU 100/7 followed immediately by DIV 0x80000000 / -1 (writes at cycles 33 and 67).
        run_div(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b0);
        run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 1'b0);
        next();

        run_div(1'b1, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 1'b0);
        next();

`ifdef HILO_DIV_DZ_TRAP_EN
        signed_op = 1'b0; a = 32'd5; b = 32'd0; start = 1'b1;
        #1;
        chk("dz_accept_stall", 64'(stall), 64'd1);
        next();
        start = 1'b0;
        #1;
        chk("dz_done", 64'({dz_err, hilo_we, hilo_flag, stall, busy}), 64'b1000001);
        chk("dz_wd_untouched", hilo_wd, 64'hFFFFFFFF_FFFFFFFD);
        next();
        #1;
        chk("dz_idle", 64'({dz_err, busy}), 64'd0);
`else
        run_div(1'b0, 32'd5, 32'd0, 64'h00000005_FFFFFFFF, 1'b0);
`endif
        next();

        // cancel together with start in IDLE drops the request
        signed_op = 1'b0; a = 32'd9; b = 32'd3; start = 1'b1; cancel = 1'b1;
        #1;
        chk("idle_cancel_stall", 64'(stall), 64'd0);
        next();
        start = 1'b0; cancel = 1'b0;
        #1;
        chk("idle_cancel_busy", 64'(busy), 64'd0);
        next();

        // cancel in BUSY at cycle 10
        start = 1'b1;
        next();
        start = 1'b0;
        for (int i = 1; i <= 9; i++) next();
        cancel = 1'b1;
        next();
        cancel = 1'b0;
        #1;
        chk("busy_cancel_c11", 64'({stall, busy}), 64'd0);
        we_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            next();
            if (hilo_we) we_cnt++;
        end
        chk("busy_cancel_no_we", 64'(we_cnt), 64'd0);

        // cancel in DONE suppresses the write
        run_div(1'b0, 32'd100, 32'd7, 64'd0, 1'b1);
        next();

        // reset mid-operation at cycle 20
        signed_op = 1'b0; a = 32'd9; b = 32'd3; start = 1'b1;
        next();
        start = 1'b0;
        for (int i = 1; i <= 19; i++) next();
        rst = 1'b0;
        next();
        #1;
        chk("midreset_ctl", 64'({stall, busy, hilo_we, hilo_flag}), 64'd0);
        chk("midreset_wd", hilo_wd, 64'd0);
        rst = 1'b1;
        we_cnt = 0;
        for (int i = 0; i < 20; i++) begin
            next();
            if (hilo_we) we_cnt++;
        end
        chk("midreset_no_we", 64'(we_cnt), 64'd0);
        run_div(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
